mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Shares one shift-add multiplier between two requesters using round-robin arbitration. The block latches the granted requester's operands and issues the single-cycle start pulse. It then waits for the multiplier's done flag and returns the product to the requester that owns it. A watchdog returns an error if the multiplier never completes. The block sits between the requesting datapaths and the multiplier's `St`, operand, `Done`, `Idle` and product ports.

## Interface
- `WIDTH`, 4: operand width; the product is 2*WIDTH bits.
- `TIMEOUT`, 31: maximum number of BUSY cycles to wait for `Mul_Done` before reporting an error.

- `Clk` in 1: the only clock; all registers update on its rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `Req0`, `Req1` in 1: request lines; each is held high, with its operands stable, until the matching `Ack` is seen.
- `A0`, `B0`, `A1`, `B1` in WIDTH: multiplicand and multiplier for each requester.
- `Ack0`, `Ack1` out 1: one-cycle grant pulse; operands are captured at this point.
- `Rdy0`, `Rdy1` out 1: one-cycle result-valid pulse to the owning requester.
- `Err0`, `Err1` out 1: one-cycle timeout pulse to the owning requester.
- `Result` out 2*WIDTH: last product returned; holds its value until the next `Rdy` or `Err`.
- `Busy` out 1: high in every state except IDLE.
- `Mul_St` out 1: start pulse to the multiplier.
- `Mul_A`, `Mul_B` out WIDTH: multiplicand and multiplier to the multiplier; held stable from START until the job ends.
- `Mul_Done` in 1: multiplier completion flag.
- `Mul_Idle` in 1: multiplier idle flag.
- `Mul_P` in 2*WIDTH: multiplier product.

## Operation
- All outputs are registered.
- States: IDLE, START, BUSY.
- Internal registers:
  - `owner`: the requester that holds the current job.
  - `last`: the requester granted most recently.
  - `cnt`: timeout counter, ceil(log2(TIMEOUT+1)) bits.
- IDLE:
  - A grant needs `Mul_Idle`=1 and at least one `Req` high.
  - With a single request, that requester wins.
  - With both requests high, the requester that is not `last` wins.
  - On the grant edge: `Mul_A`/`Mul_B` take the winner's operands, `owner` and `last` take the winner, `Ack_owner` and `Mul_St` go to 1, `cnt` is cleared, and the state moves to START.
- START (exactly 1 cycle):
  - `Ack` and `Mul_St` are high during this cycle.
  - On the next edge both fall and the state moves to BUSY.
- BUSY, evaluated each cycle:
  - `Mul_Done`=1: `Result` takes `Mul_P`, `Rdy_owner` goes to 1, and the state moves to IDLE.
  - Otherwise, if `cnt`==TIMEOUT: `Result` is cleared to 0, `Err_owner` goes to 1, and the state moves to IDLE.
  - Otherwise, `cnt` increments.
- `Mul_Done` and timeout in the same cycle: `Mul_Done` wins.
- `Mul_Done` outside BUSY is ignored.
- A `Req` still high when the block returns to IDLE is treated as a new request; a requester must drop `Req` on the edge after it sees `Ack`.
- `Result` is 2*WIDTH bits and is copied from `Mul_P` without modification.

## Timing
- Reset values:
  - State IDLE.
  - `last`=1, so requester 0 wins the first tie.
  - All `Ack`, `Rdy`, `Err` and `Mul_St` outputs 0.
  - `Busy`=0.
  - `Result`, `Mul_A` and `Mul_B` all 0.
  - `cnt`=0.
- Grant latency: with `Req` sampled high in IDLE at cycle t, `Ack` and `Mul_St` are high in cycle t+1 and low in cycle t+2.
- Return latency: with `Mul_Done` sampled high at cycle d, `Rdy` and the new `Result` are visible in cycle d+1, and the block is in IDLE in cycle d+1.
- Throughput: the earliest next `Ack` is at d+2.
- Timeout: `Err` fires TIMEOUT+1 BUSY cycles after entering BUSY.
- `Busy` is high from cycle t+1 through cycle d inclusive.
- Reset asserted mid-operation: all outputs clear immediately, including `Mul_St`. The multiplier has no reset, so after `Rst` falls the block grants nothing until `Mul_Idle`=1.
- `Mul_Idle`=0 in IDLE: requests stay pending, with no `Ack` issued.

## Test plan
- Single request: `Req0` with A0=13, B0=11. Required: `Ack0` 1 cycle later, `Mul_St` high for 1 cycle, `Rdy0` the cycle after `Mul_Done`, `Result`=143 (0x8F), and `Ack1`/`Rdy1` stay 0.
- Simultaneous requests after reset: `Req0` (15×15) and `Req1` (0×9) both held. Required order: `Ack0`, `Rdy0` with `Result`=225, then `Ack1` at `Rdy0`+1, then `Rdy1` with `Result`=0.
- Fairness: both requests held continuously for 4 jobs. Required grant order 0,1,0,1, with no two consecutive grants to the same requester.
- Timeout: a model that never asserts `Mul_Done`, TIMEOUT=31. Required: `Err1` exactly 32 BUSY cycles after START, `Result`=0, no `Rdy1`, and the block then returns to IDLE and accepts a new request.
- Reset mid-BUSY: `Rst` pulsed 2 cycles after `Ack0`. Required: `Busy`, `Mul_St` and `Result` clear immediately, and no `Rdy0`; with `Mul_Idle`=0 held, `Req1` receives no `Ack` until `Mul_Idle`=1.
- Stray `Mul_Done` in IDLE or START: no `Rdy` is issued and `Result` is unchanged.

Source files
------------

// File: rtl/mult_share_arbiter_if.sv
// rtl/mult_share_arbiter_if.sv - requester and multiplier signal bundle for mult_share_arbiter
// Ports (slave = arbiter side):
//   Req0/Req1, A0/B0/A1/B1      requester requests and operands (in)
//   Ack0/Ack1, Rdy0/Rdy1, Err0/Err1, Result, Busy   requester-facing status (out)
//   Mul_St, Mul_A, Mul_B        multiplier start and operands (out)
//   Mul_Done, Mul_Idle, Mul_P   multiplier status and product (in)
`timescale 1ns/1ps
interface mult_share_arbiter_if #(
    parameter int WIDTH = 4
);
    logic                   Req0;
    logic                   Req1;
    logic [WIDTH-1:0]       A0;
    logic [WIDTH-1:0]       B0;
    logic [WIDTH-1:0]       A1;
    logic [WIDTH-1:0]       B1;
    logic                   Ack0;
    logic                   Ack1;
    logic                   Rdy0;
    logic                   Rdy1;
    logic                   Err0;
    logic                   Err1;
    logic [2*WIDTH-1:0]     Result;
    logic                   Busy;
    logic                   Mul_St;
    logic [WIDTH-1:0]       Mul_A;
    logic [WIDTH-1:0]       Mul_B;
    logic                   Mul_Done;
    logic                   Mul_Idle;
    logic [2*WIDTH-1:0]     Mul_P;

    modport slave (
        input  Req0, Req1, A0, B0, A1, B1,
        output Ack0, Ack1, Rdy0, Rdy1, Err0, Err1, Result, Busy,
        output Mul_St, Mul_A, Mul_B,
        input  Mul_Done, Mul_Idle, Mul_P
    );

    modport master (
        output Req0, Req1, A0, B0, A1, B1,
        input  Ack0, Ack1, Rdy0, Rdy1, Err0, Err1, Result, Busy,
        input  Mul_St, Mul_A, Mul_B,
        output Mul_Done, Mul_Idle, Mul_P
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one multiplier between two requesters
// Ports:
//   Clk  - clock, rising edge
//   Rst  - asynchronous active-high reset
//   bus  - mult_share_arbiter_if.slave: requests/operands in, Ack/Rdy/Err/Result/Busy out,
//          multiplier St/A/B out, Done/Idle/P in
`timescale 1ns/1ps
module mult_share_arbiter #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 31
) (
    input  logic                  Clk,
    input  logic                  Rst,
    mult_share_arbiter_if.slave   bus
);
    localparam int             CW      = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t               r_state,   w_state_nxt;
    logic                 r_owner,   w_owner_nxt;
    logic                 r_last,    w_last_nxt;
    logic [CW-1:0]        r_cnt,     w_cnt_nxt;
    logic                 r_ack0,    w_ack0_nxt;
    logic                 r_ack1,    w_ack1_nxt;
    logic                 r_rdy0,    w_rdy0_nxt;
    logic                 r_rdy1,    w_rdy1_nxt;
    logic                 r_err0,    w_err0_nxt;
    logic                 r_err1,    w_err1_nxt;
    logic [2*WIDTH-1:0]   r_result,  w_result_nxt;
    logic                 r_busy,    w_busy_nxt;
    logic                 r_mul_st,  w_mul_st_nxt;
    logic [WIDTH-1:0]     r_mul_a,   w_mul_a_nxt;
    logic [WIDTH-1:0]     r_mul_b,   w_mul_b_nxt;
    logic                 w_win;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state  <= IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;   // requester 0 takes the first tie
            r_cnt    <= '0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdy0   <= 1'b0;
            r_rdy1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_mul_st <= 1'b0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_last   <= w_last_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ack0   <= w_ack0_nxt;
            r_ack1   <= w_ack1_nxt;
            r_rdy0   <= w_rdy0_nxt;
            r_rdy1   <= w_rdy1_nxt;
            r_err0   <= w_err0_nxt;
            r_err1   <= w_err1_nxt;
            r_result <= w_result_nxt;
            r_busy   <= w_busy_nxt;
            r_mul_st <= w_mul_st_nxt;
            r_mul_a  <= w_mul_a_nxt;
            r_mul_b  <= w_mul_b_nxt;
        end
    end

    always_comb begin
        // On a tie the requester that did not win last time is chosen.
        w_win        = (bus.Req0 && bus.Req1) ? ~r_last : bus.Req1;

        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_last_nxt   = r_last;
        w_cnt_nxt    = r_cnt;
        w_ack0_nxt   = 1'b0;
        w_ack1_nxt   = 1'b0;
        w_rdy0_nxt   = 1'b0;
        w_rdy1_nxt   = 1'b0;
        w_err0_nxt   = 1'b0;
        w_err1_nxt   = 1'b0;
        w_result_nxt = r_result;
        w_mul_st_nxt = 1'b0;
        w_mul_a_nxt  = r_mul_a;
        w_mul_b_nxt  = r_mul_b;

        case (r_state)
            IDLE: begin
                if (bus.Mul_Idle && (bus.Req0 || bus.Req1)) begin
                    w_mul_a_nxt  = w_win ? bus.A1 : bus.A0;
                    w_mul_b_nxt  = w_win ? bus.B1 : bus.B0;
                    w_owner_nxt  = w_win;
                    w_last_nxt   = w_win;
                    w_ack0_nxt   = ~w_win;
                    w_ack1_nxt   = w_win;
                    w_mul_st_nxt = 1'b1;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = START;
                end
            end
            START: begin
                w_state_nxt = BUSY;
            end
            BUSY: begin
                // A completion in the final watchdog cycle still counts as success.
                if (bus.Mul_Done) begin
                    w_result_nxt = bus.Mul_P;
                    w_rdy0_nxt   = ~r_owner;
                    w_rdy1_nxt   = r_owner;
                    w_state_nxt  = IDLE;
                end else if (r_cnt == CNT_MAX) begin
                    w_result_nxt = '0;
                    w_err0_nxt   = ~r_owner;
                    w_err1_nxt   = r_owner;
                    w_state_nxt  = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign bus.Ack0   = r_ack0;
    assign bus.Ack1   = r_ack1;
    assign bus.Rdy0   = r_rdy0;
    assign bus.Rdy1   = r_rdy1;
    assign bus.Err0   = r_err0;
    assign bus.Err1   = r_err1;
    assign bus.Result = r_result;
    assign bus.Busy   = r_busy;
    assign bus.Mul_St = r_mul_st;
    assign bus.Mul_A  = r_mul_a;
    assign bus.Mul_B  = r_mul_b;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - scoreboard bench for mult_share_arbiter
`timescale 1ns/1ps
module tb_mult_share_arbiter;
    localparam int WIDTH     = 4;
    localparam int TIMEOUT   = 31;
    localparam int MODEL_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mult_share_arbiter_if #(.WIDTH(WIDTH)) bus();

    mult_share_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { bit owner; bit is_err; logic [7:0] result; } exp_t;
    typedef struct { bit ack0; bit ack1; logic [3:0] a; logic [3:0] b; bit st; int edge_no; } ack_t;
    typedef struct { bit rdy0; bit rdy1; bit err0; bit err1; logic [7:0] result; bit busy; int edge_no; int done_edge; } res_t;

    exp_t exp_q[$];
    ack_t ack_q[$];
    res_t res_q[$];

    int checks    = 0;
    int errors    = 0;
    int edge_cnt  = 0;
    int done_edge = -100;
    int tail_cnt  = 0;

    bit never_done    = 1'b0;
    bit hold_not_idle = 1'b0;
    bit stray_done    = 1'b0;

    always @(posedge clk) begin
        if (bus.Mul_Done === 1'b1) done_edge = edge_cnt;
        edge_cnt = edge_cnt + 1;
    end

    // Shift-add multiplier stand-in, updated on the falling edge; it has no reset.
    initial begin
        logic [7:0] m_a, m_b;
        bit m_busy;
        int m_cnt;
        m_a = '0; m_b = '0; m_busy = 1'b0; m_cnt = 0;
        bus.Mul_Done = 1'b0;
        bus.Mul_P    = '0;
        bus.Mul_Idle = 1'b1;
        forever begin
            @(negedge clk);
            bus.Mul_Done = 1'b0;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    bus.Mul_Done = 1'b1;
                    bus.Mul_P    = m_a * m_b;
                    m_busy       = 1'b0;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end else if (bus.Mul_St === 1'b1 && !never_done) begin
                m_a    = {4'b0, bus.Mul_A};
                m_b    = {4'b0, bus.Mul_B};
                m_busy = 1'b1;
                m_cnt  = MODEL_LAT;
            end
            if (stray_done) begin
                bus.Mul_Done = 1'b1;
                bus.Mul_P    = 8'hAA;
            end
            bus.Mul_Idle = !m_busy && !hold_not_idle;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs until njobs Rdy/Err pulses are seen, logging every Ack and result pulse.
    task automatic run_jobs(input int njobs, input int budget, input bit drop_on_ack, output bit timed_out);
        int got = 0;
        int n = 0;
        bit prev_pulse = 1'b0;
        timed_out = 1'b0;
        while (got < njobs) begin
            if (n >= budget) begin
                timed_out = 1'b1;
                break;
            end
            step();
            n++;
            if (prev_pulse && (bus.Ack0 || bus.Ack1 || bus.Mul_St)) tail_cnt++;
            prev_pulse = bus.Ack0 || bus.Ack1 || bus.Mul_St;
            if (bus.Ack0 || bus.Ack1) begin
                ack_q.push_back('{bus.Ack0, bus.Ack1, bus.Mul_A, bus.Mul_B, bus.Mul_St, edge_cnt});
                if (drop_on_ack && bus.Ack0) bus.Req0 = 1'b0;
                if (drop_on_ack && bus.Ack1) bus.Req1 = 1'b0;
            end
            if (bus.Rdy0 || bus.Rdy1 || bus.Err0 || bus.Err1) begin
                res_q.push_back('{bus.Rdy0, bus.Rdy1, bus.Err0, bus.Err1, bus.Result, bus.Busy, edge_cnt, done_edge});
                got++;
            end
        end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
    endtask

    task automatic clear_logs();
        ack_q.delete();
        res_q.delete();
        tail_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
        checks++; if ({bus.Ack0, bus.Ack1, bus.Rdy0, bus.Rdy1, bus.Err0, bus.Err1, bus.Mul_St} !== 7'b0) begin
            errors++; $display("FAIL reset_pulses: got %b expected 0000000", {bus.Ack0, bus.Ack1, bus.Rdy0, bus.Rdy1, bus.Err0, bus.Err1, bus.Mul_St}); end
        checks++; if ({bus.Result, bus.Mul_A, bus.Mul_B} !== 16'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0000", {bus.Result, bus.Mul_A, bus.Mul_B}); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        bit to;
        int start_edge;
        exp_t e;
        clear_logs();
        bus.A0 = 4'd13; bus.B0 = 4'd11; bus.Req0 = 1'b1;
        exp_q.push_back('{1'b0, 1'b0, 8'd143});
        start_edge = edge_cnt;
        run_jobs(1, 40, 1'b1, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL single_timeout: no result within budget"); end
        checks++; if (ack_q.size() != 1) begin errors++; $display("FAIL single_ack_count: got %0d expected 1", ack_q.size()); end
        else begin
            checks++; if ({ack_q[0].ack0, ack_q[0].ack1, ack_q[0].st} !== 3'b101) begin
                errors++; $display("FAIL single_ack: got ack0/ack1/st %b expected 101", {ack_q[0].ack0, ack_q[0].ack1, ack_q[0].st}); end
            checks++; if (ack_q[0].edge_no != start_edge + 1) begin
                errors++; $display("FAIL single_grant_latency: got edge %0d expected %0d", ack_q[0].edge_no, start_edge + 1); end
            checks++; if ({ack_q[0].a, ack_q[0].b} !== {4'd13, 4'd11}) begin
                errors++; $display("FAIL single_operands: got %h expected db", {ack_q[0].a, ack_q[0].b}); end
        end
        checks++; if (tail_cnt != 0) begin errors++; $display("FAIL single_pulse_width: got %0d long pulses expected 0", tail_cnt); end
        checks++; if (res_q.size() != 1) begin errors++; $display("FAIL single_res_count: got %0d expected 1", res_q.size()); end
        else begin
            e = exp_q.pop_front();
            checks++; if ({res_q[0].rdy0, res_q[0].rdy1, res_q[0].err0, res_q[0].err1} !== {~e.owner, e.owner, 2'b00}) begin
                errors++; $display("FAIL single_rdy: got %b expected 1000", {res_q[0].rdy0, res_q[0].rdy1, res_q[0].err0, res_q[0].err1}); end
            checks++; if (res_q[0].result !== e.result) begin
                errors++; $display("FAIL single_result: got %0d expected %0d", res_q[0].result, e.result); end
            checks++; if (res_q[0].edge_no != res_q[0].done_edge + 1) begin
                errors++; $display("FAIL single_return_latency: got edge %0d expected %0d", res_q[0].edge_no, res_q[0].done_edge + 1); end
            checks++; if (res_q[0].busy !== 1'b0) begin errors++; $display("FAIL single_busy_at_rdy: got %b expected 0", res_q[0].busy); end
        end
        exp_q.delete();
    endtask

    task automatic test_simultaneous();
        bit to;
        exp_t e;
        rst = 1'b1; step(); rst = 1'b0; step();
        clear_logs();
        bus.A0 = 4'd15; bus.B0 = 4'd15; bus.A1 = 4'd0; bus.B1 = 4'd9;
        bus.Req0 = 1'b1; bus.Req1 = 1'b1;
        exp_q.push_back('{1'b0, 1'b0, 8'd225});
        exp_q.push_back('{1'b1, 1'b0, 8'd0});
        run_jobs(2, 80, 1'b1, to);
        checks++; if (to !== 1'b0 || ack_q.size() != 2 || res_q.size() != 2) begin
            errors++; $display("FAIL sim_counts: got to=%b acks=%0d results=%0d expected 0/2/2", to, ack_q.size(), res_q.size()); end
        else begin
            checks++; if ({ack_q[0].ack0, ack_q[1].ack1} !== 2'b11) begin
                errors++; $display("FAIL sim_order: got %b expected 11", {ack_q[0].ack0, ack_q[1].ack1}); end
            checks++; if (ack_q[1].edge_no != res_q[0].edge_no + 1) begin
                errors++; $display("FAIL sim_throughput: got ack1 edge %0d expected %0d", ack_q[1].edge_no, res_q[0].edge_no + 1); end
            for (int i = 0; i < 2; i++) begin
                e = exp_q.pop_front();
                checks++; if ({res_q[i].rdy0, res_q[i].rdy1, res_q[i].result} !== {~e.owner, e.owner, e.result}) begin
                    errors++; $display("FAIL sim_result%0d: got rdy %b%b result %0d expected rdy %b%b result %0d",
                        i, res_q[i].rdy0, res_q[i].rdy1, res_q[i].result, ~e.owner, e.owner, e.result); end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_fairness();
        bit to;
        exp_t e;
        clear_logs();
        bus.A0 = 4'd3; bus.B0 = 4'd5; bus.A1 = 4'd7; bus.B1 = 4'd9;
        bus.Req0 = 1'b1; bus.Req1 = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back('{bit'(i % 2), 1'b0, (i % 2) ? 8'd63 : 8'd15});
        run_jobs(4, 160, 1'b0, to);
        checks++; if (to !== 1'b0 || ack_q.size() != 4 || res_q.size() != 4) begin
            errors++; $display("FAIL fair_counts: got to=%b acks=%0d results=%0d expected 0/4/4", to, ack_q.size(), res_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                e = exp_q.pop_front();
                checks++; if (ack_q[i].ack1 !== e.owner || ack_q[i].ack0 !== ~e.owner) begin
                    errors++; $display("FAIL fair_grant%0d: got ack1=%b expected %b", i, ack_q[i].ack1, e.owner); end
                checks++; if (res_q[i].rdy1 !== e.owner || res_q[i].result !== e.result) begin
                    errors++; $display("FAIL fair_result%0d: got rdy1=%b result %0d expected %b %0d",
                        i, res_q[i].rdy1, res_q[i].result, e.owner, e.result); end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_timeout();
        bit to;
        exp_t e;
        clear_logs();
        never_done = 1'b1;
        bus.A1 = 4'd5; bus.B1 = 4'd6; bus.Req1 = 1'b1;
        exp_q.push_back('{1'b1, 1'b1, 8'd0});
        run_jobs(1, 80, 1'b1, to);
        never_done = 1'b0;
        checks++; if (to !== 1'b0 || ack_q.size() != 1 || res_q.size() != 1) begin
            errors++; $display("FAIL tmo_counts: got to=%b acks=%0d results=%0d expected 0/1/1", to, ack_q.size(), res_q.size()); end
        else begin
            e = exp_q.pop_front();
            checks++; if ({res_q[0].rdy0, res_q[0].rdy1, res_q[0].err0, res_q[0].err1} !== {2'b00, ~e.owner, e.owner}) begin
                errors++; $display("FAIL tmo_err: got rdy/err %b expected 0001", {res_q[0].rdy0, res_q[0].rdy1, res_q[0].err0, res_q[0].err1}); end
            checks++; if (res_q[0].result !== e.result) begin
                errors++; $display("FAIL tmo_result: got %0d expected %0d", res_q[0].result, e.result); end
            checks++; if (res_q[0].edge_no != ack_q[0].edge_no + TIMEOUT + 2) begin
                errors++; $display("FAIL tmo_latency: got edge %0d expected %0d", res_q[0].edge_no, ack_q[0].edge_no + TIMEOUT + 2); end
        end
        exp_q.delete();
        clear_logs();
        bus.A0 = 4'd2; bus.B0 = 4'd3; bus.Req0 = 1'b1;
        exp_q.push_back('{1'b0, 1'b0, 8'd6});
        run_jobs(1, 40, 1'b1, to);
        checks++; if (to !== 1'b0 || res_q.size() != 1) begin
            errors++; $display("FAIL tmo_recover: got to=%b results=%0d expected 0/1", to, res_q.size()); end
        else begin
            e = exp_q.pop_front();
            checks++; if ({res_q[0].rdy0, res_q[0].result} !== {~e.owner, e.result}) begin
                errors++; $display("FAIL tmo_recover_result: got rdy0=%b result %0d expected 1 %0d", res_q[0].rdy0, res_q[0].result, e.result); end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_busy();
        bit to;
        bit seen = 1'b0;
        int bad = 0;
        int release_edge;
        exp_t e;
        bus.A0 = 4'd9; bus.B0 = 4'd9; bus.Req0 = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = bus.Ack0;
        end
        bus.Req0 = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL rmb_ack0: got no Ack0 expected one within 10 cycles"); end
        step(); step();
        rst = 1'b1; hold_not_idle = 1'b1;
        #1;
        checks++; if ({bus.Busy, bus.Mul_St, bus.Rdy0} !== 3'b000) begin
            errors++; $display("FAIL rmb_clear: got busy/st/rdy0 %b expected 000", {bus.Busy, bus.Mul_St, bus.Rdy0}); end
        checks++; if (bus.Result !== 8'd0) begin errors++; $display("FAIL rmb_result: got %0d expected 0", bus.Result); end
        step();
        rst = 1'b0;
        bus.A1 = 4'd4; bus.B1 = 4'd4; bus.Req1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.Ack0 || bus.Ack1 || bus.Rdy0 || bus.Rdy1 || bus.Err0 || bus.Err1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rmb_hold: got %0d pulses while Mul_Idle=0 expected 0", bad); end
        clear_logs();
        hold_not_idle = 1'b0;
        release_edge = edge_cnt;
        exp_q.push_back('{1'b1, 1'b0, 8'd16});
        run_jobs(1, 40, 1'b1, to);
        checks++; if (to !== 1'b0 || ack_q.size() != 1 || res_q.size() != 1) begin
            errors++; $display("FAIL rmb_counts: got to=%b acks=%0d results=%0d expected 0/1/1", to, ack_q.size(), res_q.size()); end
        else begin
            e = exp_q.pop_front();
            checks++; if (ack_q[0].ack1 !== 1'b1 || ack_q[0].edge_no <= release_edge) begin
                errors++; $display("FAIL rmb_grant: got ack1=%b at edge %0d expected 1 after %0d", ack_q[0].ack1, ack_q[0].edge_no, release_edge); end
            checks++; if ({res_q[0].rdy1, res_q[0].result} !== {e.owner, e.result}) begin
                errors++; $display("FAIL rmb_result: got rdy1=%b result %0d expected 1 %0d", res_q[0].rdy1, res_q[0].result, e.result); end
        end
        exp_q.delete();
    endtask

    task automatic test_stray_done();
        bit to;
        bit seen = 1'b0;
        int bad = 0;
        exp_t e;
        step();
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.Rdy0 || bus.Rdy1 || bus.Err0 || bus.Err1) bad++;
        end
        checks++; if (bad != 0 || bus.Result !== 8'd16) begin
            errors++; $display("FAIL stray_idle: got %0d pulses result %0d expected 0 pulses result 16", bad, bus.Result); end
        bus.A0 = 4'd7; bus.B0 = 4'd6; bus.Req0 = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = bus.Ack0;
        end
        bus.Req0 = 1'b0;
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        checks++; if (!seen || bus.Rdy0 !== 1'b0 || bus.Result !== 8'd16) begin
            errors++; $display("FAIL stray_start: got ack=%b rdy0=%b result %0d expected 1 0 16", seen, bus.Rdy0, bus.Result); end
        clear_logs();
        exp_q.push_back('{1'b0, 1'b0, 8'd42});
        run_jobs(1, 20, 1'b1, to);
        checks++; if (to !== 1'b0 || res_q.size() != 1) begin
            errors++; $display("FAIL stray_job: got to=%b results=%0d expected 0/1", to, res_q.size()); end
        else begin
            e = exp_q.pop_front();
            checks++; if ({res_q[0].rdy0, res_q[0].result} !== {~e.owner, e.result}) begin
                errors++; $display("FAIL stray_result: got rdy0=%b result %0d expected 1 %0d", res_q[0].rdy0, res_q[0].result, e.result); end
        end
        exp_q.delete();
    endtask

    initial begin
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_reset_mid_busy();
        test_stray_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
